// File: rtl/trs_io_bus_frontend.sv
// -----------------------------------------------------------------------------
// trs_io_bus_frontend
//
// Front-end between the raw, asynchronous TRS-80 Z80 I/O bus and the FPGA
// port-decode blocks (including the hires video block at ports 0x80-0x83).
//
// The block synchronises the raw bus and deglitches the IN/OUT strobes. Once a
// strobe has been accepted it latches the address and data, and it issues
// exactly one single-cycle io_access per bus cycle. An IN cycle to RD_PORT is
// stretched with TRS_WAIT until the hires block returns a byte, or until a
// timeout forces an 0xFF reply. The reply is then driven until the strobe
// releases.
//
// Ports:
//   clk              system clock
//   srst             asynchronous, active-high reset
//   TRS_A_async      raw bus address (9 bits)
//   TRS_D_async      raw bus write data (8 bits)
//   TRS_OUT_async_n  raw OUT strobe, active-low
//   TRS_IN_async_n   raw IN strobe, active-low
//   hires_dout       read data from the hires block
//   hires_dout_rdy   one-cycle pulse, hires_dout valid
//   TRS_A            latched address (frozen from ACC through HOLD)
//   TRS_D            latched write data (frozen from ACC through HOLD)
//   TRS_OUT          qualified OUT strobe, active-low
//   TRS_IN           qualified IN strobe, active-low
//   io_access        one-cycle access pulse
//   TRS_WAIT         high = stretch the Z80 cycle
//   trs_dout         data to the Z80 data-bus driver
//   trs_dout_oe      enable for the data-bus driver
//   rd_timeout       one-cycle pulse when a hires read times out
// -----------------------------------------------------------------------------
module trs_io_bus_frontend #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER      = 3,
  parameter int         TIMEOUT     = 64,
  parameter logic [8:0] RD_PORT     = 9'h082
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [8:0] TRS_A_async,
  input  logic [7:0] TRS_D_async,
  input  logic       TRS_OUT_async_n,
  input  logic       TRS_IN_async_n,
  input  logic [7:0] hires_dout,
  input  logic       hires_dout_rdy,
  output logic [8:0] TRS_A,
  output logic [7:0] TRS_D,
  output logic       TRS_OUT,
  output logic       TRS_IN,
  output logic       io_access,
  output logic       TRS_WAIT,
  output logic [7:0] trs_dout,
  output logic       trs_dout_oe,
  output logic       rd_timeout
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUAL   = 3'd1,
    ST_ACC    = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. Index 0 is the newest sample and the top index is the synced
  // value. Strobe stages reset to 0 (asserted), so a strobe has to be seen high
  // for the full chain plus the filter before the FSM leaves HOLD.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][8:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0][7:0] d_sync_q, d_sync_d;
  logic [SYNC_STAGES-1:0]      out_n_sync_q, out_n_sync_d;
  logic [SYNC_STAGES-1:0]      in_n_sync_q, in_n_sync_d;

  logic [8:0] a_s;
  logic [7:0] d_s;
  logic       out_lo_s;
  logic       in_lo_s;
  logic       sel_lo_s;

  // Next value of each synchroniser chain: shift in the raw bus.
  always_comb begin
    a_sync_d     = {a_sync_q[SYNC_STAGES-2:0], TRS_A_async};
    d_sync_d     = {d_sync_q[SYNC_STAGES-2:0], TRS_D_async};
    out_n_sync_d = {out_n_sync_q[SYNC_STAGES-2:0], TRS_OUT_async_n};
    in_n_sync_d  = {in_n_sync_q[SYNC_STAGES-2:0], TRS_IN_async_n};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      a_sync_q     <= '0;
      d_sync_q     <= '0;
      out_n_sync_q <= '0;
      in_n_sync_q  <= '0;
    end else begin
      a_sync_q     <= a_sync_d;
      d_sync_q     <= d_sync_d;
      out_n_sync_q <= out_n_sync_d;
      in_n_sync_q  <= in_n_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus-cycle FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          sel_in_q, sel_in_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [8:0]    ta_q, ta_d;
  logic [7:0]    td_q, td_d;
  logic          trs_out_q, trs_out_d;
  logic          trs_in_q, trs_in_d;
  logic          io_access_q, io_access_d;
  logic          wait_q, wait_d;
  logic [7:0]    dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          rd_timeout_q, rd_timeout_d;

  // Synced bus views used by the FSM.
  always_comb begin
    a_s      = a_sync_q[SYNC_STAGES-1];
    d_s      = d_sync_q[SYNC_STAGES-1];
    out_lo_s = ~out_n_sync_q[SYNC_STAGES-1];
    in_lo_s  = ~in_n_sync_q[SYNC_STAGES-1];
    // The strobe being qualified is low and the other one is not.
    if (sel_in_q) begin
      sel_lo_s = in_lo_s & ~out_lo_s;
    end else begin
      sel_lo_s = out_lo_s & ~in_lo_s;
    end
  end

  // Next-state and next-output logic of the bus-cycle FSM.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    sel_in_d     = sel_in_q;
    tmo_d        = tmo_q;
    ta_d         = ta_q;
    td_d         = td_q;
    trs_out_d    = trs_out_q;
    trs_in_d     = trs_in_q;
    io_access_d  = 1'b0;
    wait_d       = wait_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    rd_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ta_d = a_s;
        td_d = d_s;
        if (out_lo_s && in_lo_s) begin
          // Both strobes at once is not a legal Z80 cycle: wait it out.
          state_d = ST_HOLD;
          fcnt_d  = '0;
        end else if (out_lo_s || in_lo_s) begin
          state_d  = ST_QUAL;
          fcnt_d   = FW'(1);
          sel_in_d = in_lo_s;
        end else begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end
      end

      ST_QUAL: begin
        ta_d = a_s;
        td_d = d_s;
        if (sel_lo_s) begin
          if (fcnt_q == FW'(FILTER)) begin
            // Accepted: this edge is the last address/data capture.
            state_d     = ST_ACC;
            fcnt_d      = '0;
            tmo_d       = '0;
            io_access_d = 1'b1;
            if (sel_in_q) begin
              trs_in_d = 1'b0;
              wait_d   = (a_s == RD_PORT);
            end else begin
              trs_out_d = 1'b0;
              wait_d    = 1'b0;
            end
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end else begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end
      end

      ST_ACC: begin
        fcnt_d = '0;
        tmo_d  = '0;
        if (sel_in_q && (ta_q == RD_PORT)) begin
          state_d = ST_RDWAIT;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_RDWAIT: begin
        fcnt_d = '0;
        if (!in_lo_s) begin
          // Z80 dropped IN without waiting: release WAIT, never drive the bus.
          state_d = ST_HOLD;
          wait_d  = 1'b0;
        end else if (hires_dout_rdy) begin
          // Data beats the timeout when both land on the same cycle.
          state_d = ST_HOLD;
          wait_d  = 1'b0;
          dout_d  = hires_dout;
          oe_d    = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d      = ST_HOLD;
          wait_d       = 1'b0;
          dout_d       = 8'hFF;
          oe_d         = 1'b1;
          rd_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_HOLD: begin
        if (!out_lo_s && !in_lo_s) begin
          if (fcnt_q == FW'(FILTER - 1)) begin
            state_d   = ST_IDLE;
            fcnt_d    = '0;
            trs_out_d = 1'b1;
            trs_in_d  = 1'b1;
            oe_d      = 1'b0;
            dout_d    = 8'hFF;
            wait_d    = 1'b0;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end else begin
          fcnt_d = '0;
        end
      end

      default: begin
        // Unreachable encoding: park safely until the bus is quiet.
        state_d   = ST_HOLD;
        fcnt_d    = '0;
        wait_d    = 1'b0;
        oe_d      = 1'b0;
        dout_d    = 8'hFF;
        trs_out_d = 1'b1;
        trs_in_d  = 1'b1;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q      <= ST_HOLD;
      fcnt_q       <= '0;
      sel_in_q     <= 1'b0;
      tmo_q        <= '0;
      ta_q         <= 9'h000;
      td_q         <= 8'h00;
      trs_out_q    <= 1'b1;
      trs_in_q     <= 1'b1;
      io_access_q  <= 1'b0;
      wait_q       <= 1'b0;
      dout_q       <= 8'hFF;
      oe_q         <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      sel_in_q     <= sel_in_d;
      tmo_q        <= tmo_d;
      ta_q         <= ta_d;
      td_q         <= td_d;
      trs_out_q    <= trs_out_d;
      trs_in_q     <= trs_in_d;
      io_access_q  <= io_access_d;
      wait_q       <= wait_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end

  assign TRS_A       = ta_q;
  assign TRS_D       = td_q;
  assign TRS_OUT     = trs_out_q;
  assign TRS_IN      = trs_in_q;
  assign io_access   = io_access_q;
  assign TRS_WAIT    = wait_q;
  assign trs_dout    = dout_q;
  assign trs_dout_oe = oe_q;
  assign rd_timeout  = rd_timeout_q;

endmodule
